// File: rtl/fas_pkg.sv
// -----------------------------------------------------------------------------
// fas_pkg
// Shared constants and types for the spectrum-analysis (FAS) path.
//   NUM_BINS        : bins per FFT frame
//   BIN_IDX_W       : width of a bin index
//   DATA_WIDTH_DEF  : default width of one packed power word
//   IN_WIDTH_DEF    : default signed width of one FFT component
//   fas_state_e     : frame collector state encoding
// -----------------------------------------------------------------------------
package fas_pkg;

    localparam int NUM_BINS       = 16;
    localparam int BIN_IDX_W      = 4;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int IN_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2
    } fas_state_e;

endpackage

// File: rtl/fft_frame_collector_if.sv
// -----------------------------------------------------------------------------
// fft_frame_collector_if
// Bundles the FFT input stream, the packed power bus and the analysis
// handshake seen by the frame collector.
//   slave  : the frame collector (consumes the FFT stream, drives results)
//   master : the environment (FFT core, analysis block)
// Signals:
//   fft_valid/fft_ready/fft_sof/fft_re/fft_im : streamed complex bins
//   fft_res_out    : packed powers, bin k at [k*DATA_WIDTH +: DATA_WIDTH]
//   analysis_start : start pulse to the analysis block
//   analysis_done  : analysis finished, highest valid while high
//   highest        : peak bin index from the analysis block
//   freq_valid/freq_idx : result strobe and latched peak index
//   frame_cnt      : completed frames (wraps)
//   frame_err      : framing error pulse
// -----------------------------------------------------------------------------
interface fft_frame_collector_if #(
    parameter int DATA_WIDTH = fas_pkg::DATA_WIDTH_DEF,
    parameter int IN_WIDTH   = fas_pkg::IN_WIDTH_DEF
);
    logic                                       fft_valid;
    logic                                       fft_ready;
    logic                                       fft_sof;
    logic signed [IN_WIDTH-1:0]                 fft_re;
    logic signed [IN_WIDTH-1:0]                 fft_im;
    logic [DATA_WIDTH*fas_pkg::NUM_BINS-1:0]    fft_res_out;
    logic                                       analysis_start;
    logic                                       analysis_done;
    logic [fas_pkg::BIN_IDX_W-1:0]              highest;
    logic                                       freq_valid;
    logic [fas_pkg::BIN_IDX_W-1:0]              freq_idx;
    logic [7:0]                                 frame_cnt;
    logic                                       frame_err;

    modport slave (
        input  fft_valid, fft_sof, fft_re, fft_im, analysis_done, highest,
        output fft_ready, fft_res_out, analysis_start, freq_valid, freq_idx,
               frame_cnt, frame_err
    );

    modport master (
        output fft_valid, fft_sof, fft_re, fft_im, analysis_done, highest,
        input  fft_ready, fft_res_out, analysis_start, freq_valid, freq_idx,
               frame_cnt, frame_err
    );
endinterface

// File: rtl/fft_frame_collector_bin_power.sv
// -----------------------------------------------------------------------------
// bin_power
// Combinational power of one complex bin: re*re + im*im, unsigned.
//   re, im : signed IN_WIDTH components
//   power  : unsigned DATA_WIDTH result (DATA_WIDTH >= 2*IN_WIDTH)
// -----------------------------------------------------------------------------
module bin_power #(
    parameter int IN_WIDTH   = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic signed [IN_WIDTH-1:0] re,
    input  logic signed [IN_WIDTH-1:0] im,
    output logic [DATA_WIDTH-1:0]      power
);
    logic signed [2*IN_WIDTH-1:0] re_x;
    logic signed [2*IN_WIDTH-1:0] im_x;
    logic        [2*IN_WIDTH-1:0] re_sq;
    logic        [2*IN_WIDTH-1:0] im_sq;

    always_comb begin
        // Sign-extend before multiplying so the square is formed at full width.
        re_x  = (2*IN_WIDTH)'(re);
        im_x  = (2*IN_WIDTH)'(im);
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        // Squares are non-negative, so the sum is taken unsigned; the worst
        // case 2*(2^(IN_WIDTH-1))^2 = 2^(2*IN_WIDTH-1) still fits.
        power = DATA_WIDTH'(re_sq) + DATA_WIDTH'(im_sq);
    end
endmodule

// File: rtl/fft_frame_collector.sv
// -----------------------------------------------------------------------------
// fft_frame_collector
// Collects a 16-bin complex FFT frame, stores each bin's power in a packed
// buffer, starts the analysis block, holds the buffer until analysis_done and
// then reports the returned peak index.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : fft_frame_collector_if.slave (stream in, buffer/results out)
// -----------------------------------------------------------------------------
module fft_frame_collector
    import fas_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IN_WIDTH   = IN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_frame_collector_if.slave  bus
);
    fas_state_e                             state_q, state_d;
    logic [BIN_IDX_W-1:0]                   bin_cnt_q, bin_cnt_d;
    logic [NUM_BINS-1:0][DATA_WIDTH-1:0]    res_q, res_d;
    logic [BIN_IDX_W-1:0]                   freq_idx_q, freq_idx_d;
    logic [7:0]                             frame_cnt_q, frame_cnt_d;
    logic                                   start_q, start_d;
    logic                                   freq_valid_q, freq_valid_d;
    logic                                   frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0]                  power;
    logic                                   accept;

    bin_power #(
        .IN_WIDTH   (IN_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bin_power (
        .re    (bus.fft_re),
        .im    (bus.fft_im),
        .power (power)
    );

    assign bus.fft_ready      = (state_q == COLLECT);
    assign accept             = bus.fft_valid && (state_q == COLLECT);
    assign bus.fft_res_out    = res_q;
    assign bus.analysis_start = start_q;
    assign bus.freq_valid     = freq_valid_q;
    assign bus.freq_idx       = freq_idx_q;
    assign bus.frame_cnt      = frame_cnt_q;
    assign bus.frame_err      = frame_err_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        bin_cnt_d    = bin_cnt_q;
        res_d        = res_q;
        freq_idx_d   = freq_idx_q;
        frame_cnt_d  = frame_cnt_q;
        start_d      = 1'b0;
        freq_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (bus.fft_sof) begin
                        // Start-of-frame always restarts at slot 0; arriving
                        // mid-frame is a framing error.
                        res_d[0]    = power;
                        bin_cnt_d   = BIN_IDX_W'(1);
                        frame_err_d = (bin_cnt_q != '0);
                    end else begin
                        res_d[bin_cnt_q] = power;
                        if (bin_cnt_q == BIN_IDX_W'(NUM_BINS - 1)) begin
                            bin_cnt_d = '0;
                            state_d   = START;
                            start_d   = 1'b1;
                        end else begin
                            bin_cnt_d = bin_cnt_q + 1'b1;
                        end
                    end
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.analysis_done) begin
                    freq_idx_d   = bus.highest;
                    freq_valid_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    state_d      = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            bin_cnt_q    <= '0;
            // NOTE: the power buffer is a bank of flops, not a RAM, so it is
            // cleared on reset like any other register.
            res_q        <= '0;
            freq_idx_q   <= '0;
            frame_cnt_q  <= '0;
            start_q      <= 1'b0;
            freq_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_cnt_q    <= bin_cnt_d;
            res_q        <= res_d;
            freq_idx_q   <= freq_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            start_q      <= start_d;
            freq_valid_q <= freq_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end
endmodule
